// File: rtl/bp_be_fe_cmd_gen.sv
// Backend-to-frontend command generator: arbitrates redirect / ITLB-fill / fence
// requests, stamps an issue tag, and queues commands toward the FE command port.
module bp_be_fe_cmd_gen #(
  parameter int vaddr_width_p = 39,
  parameter int ptag_width_p  = 28,
  parameter int fifo_els_p    = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  output logic                     redirect_ready_o,

  input  logic                     itlb_fill_v_i,
  input  logic [vaddr_width_p-1:0] itlb_fill_vaddr_i,
  input  logic [ptag_width_p-1:0]  itlb_fill_ptag_i,
  output logic                     itlb_fill_ready_o,

  input  logic                     fence_v_i,
  output logic                     fence_ready_o,

  output logic                     fe_cmd_v_o,
  output logic [2:0]               fe_cmd_opcode_o,
  output logic [vaddr_width_p-1:0] fe_cmd_vaddr_o,
  output logic [ptag_width_p-1:0]  fe_cmd_ptag_o,
  output logic [7:0]               fe_cmd_itag_o,
  input  logic                     fe_cmd_ready_i,

  output logic                     idle_o
);

  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(fifo_els_p);
  localparam logic [63:0] boot_pc = 64'h0000_0000_8000_0124;

  localparam logic [2:0] op_state_reset  = 3'd0;
  localparam logic [2:0] op_pc_redirect  = 3'd1;
  localparam logic [2:0] op_itlb_fill    = 3'd2;
  localparam logic [2:0] op_icache_fence = 3'd3;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_FENCE_WAIT
  } state_e;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [vaddr_width_p-1:0] vaddr;
    logic [ptag_width_p-1:0]  ptag;
    logic [7:0]               itag;
  } cmd_t;

  state_e           state_q, state_d;
  logic [7:0]       itag_q, itag_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  cmd_t             cmd_mem [fifo_els_p];

  cmd_t head;
  cmd_t enq_cmd;
  logic enq, deq, full, run;

  assign head = cmd_mem[rd_ptr_q];
  assign full = (count_q == full_cnt);
  assign run  = (state_q == ST_RUN);
  assign deq  = fe_cmd_v_o & fe_cmd_ready_i;

  // Ready depends only on not-full, so a full FIFO refuses even while draining.
  assign redirect_ready_o  = run & ~full;
  assign itlb_fill_ready_o = run & ~full & ~redirect_v_i;
  assign fence_ready_o     = run & ~full & ~redirect_v_i & ~itlb_fill_v_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d        = state_q;
    enq            = 1'b0;
    enq_cmd        = '0;
    enq_cmd.itag   = itag_q;

    case (state_q)
      ST_INIT: begin
        enq           = 1'b1;
        enq_cmd.opcode = op_state_reset;
        enq_cmd.vaddr  = boot_pc[vaddr_width_p-1:0];
        state_d        = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_ready_o && redirect_v_i) begin
          enq            = 1'b1;
          enq_cmd.opcode = op_pc_redirect;
          enq_cmd.vaddr  = redirect_pc_i;
        end else if (itlb_fill_ready_o && itlb_fill_v_i) begin
          enq            = 1'b1;
          enq_cmd.opcode = op_itlb_fill;
          enq_cmd.vaddr  = itlb_fill_vaddr_i;
          enq_cmd.ptag   = itlb_fill_ptag_i;
        end else if (fence_ready_o && fence_v_i) begin
          enq            = 1'b1;
          enq_cmd.opcode = op_icache_fence;
          state_d        = ST_FENCE_WAIT;
        end
      end
      ST_FENCE_WAIT: begin
        if (deq && head.opcode == op_icache_fence) state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase

    itag_d   = enq ? itag_q + 8'd1 : itag_q;
    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + cnt_w'(enq) - cnt_w'(deq);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_INIT;
      itag_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      itag_q   <= itag_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count qualifies it and outputs are zeroed when empty.
  always_ff @(posedge clk_i) begin
    if (enq) cmd_mem[wr_ptr_q] <= enq_cmd;
  end

  assign fe_cmd_v_o      = (count_q != '0);
  assign fe_cmd_opcode_o = fe_cmd_v_o ? head.opcode : '0;
  assign fe_cmd_vaddr_o  = fe_cmd_v_o ? head.vaddr  : '0;
  assign fe_cmd_ptag_o   = fe_cmd_v_o ? head.ptag   : '0;
  assign fe_cmd_itag_o   = fe_cmd_v_o ? head.itag   : '0;
  assign idle_o          = run & ~fe_cmd_v_o;

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Directed bench for bp_be_fe_cmd_gen: boot command, arbitration, back-pressure,
// fence blocking, itag wrap and mid-run reset.
module tb_bp_be_fe_cmd_gen;

  localparam int va_w = 39;
  localparam int pt_w = 28;
  localparam int hw   = 1 + 3 + va_w + pt_w + 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            redirect_v = 1'b0;
  logic [va_w-1:0] redirect_pc = '0;
  logic            redirect_ready;
  logic            fill_v = 1'b0;
  logic [va_w-1:0] fill_vaddr = '0;
  logic [pt_w-1:0] fill_ptag = '0;
  logic            fill_ready;
  logic            fence_v = 1'b0;
  logic            fence_ready;
  logic            cmd_v;
  logic [2:0]      cmd_opcode;
  logic [va_w-1:0] cmd_vaddr;
  logic [pt_w-1:0] cmd_ptag;
  logic [7:0]      cmd_itag;
  logic            cmd_ready = 1'b1;
  logic            idle;

  int vectors = 0;
  int miscompares = 0;

  bp_be_fe_cmd_gen #(.vaddr_width_p(va_w), .ptag_width_p(pt_w), .fifo_els_p(2)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .redirect_v_i(redirect_v), .redirect_pc_i(redirect_pc), .redirect_ready_o(redirect_ready),
    .itlb_fill_v_i(fill_v), .itlb_fill_vaddr_i(fill_vaddr), .itlb_fill_ptag_i(fill_ptag),
    .itlb_fill_ready_o(fill_ready),
    .fence_v_i(fence_v), .fence_ready_o(fence_ready),
    .fe_cmd_v_o(cmd_v), .fe_cmd_opcode_o(cmd_opcode), .fe_cmd_vaddr_o(cmd_vaddr),
    .fe_cmd_ptag_o(cmd_ptag), .fe_cmd_itag_o(cmd_itag), .fe_cmd_ready_i(cmd_ready),
    .idle_o(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [hw-1:0] head();
    return {cmd_v, cmd_opcode, cmd_vaddr, cmd_ptag, cmd_itag};
  endfunction

  function automatic logic [hw-1:0] exp_head(input logic [2:0] op, input logic [va_w-1:0] va,
                                             input logic [pt_w-1:0] pt, input logic [7:0] tag);
    return {1'b1, op, va, pt, tag};
  endfunction

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({cmd_v, cmd_opcode, cmd_vaddr, cmd_ptag, cmd_itag} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", head());
    end
    vectors++;
    if ({redirect_ready, fill_ready, fence_ready, idle} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready_idle: got %b want 0000",
                              {redirect_ready, fill_ready, fence_ready, idle});
    end
    step();
    reset_n = 1'b1;
    #1;
    vectors++;
    if ({redirect_ready, idle, cmd_v} !== 3'b000) begin
      miscompares++; $display("FAIL init_ready: got %b want 000", {redirect_ready, idle, cmd_v});
    end
    step();
    vectors++;
    if (head() !== exp_head(3'd0, 39'h00_8000_0124, '0, 8'd0)) begin
      miscompares++; $display("FAIL boot_cmd: got %h want %h", head(), exp_head(3'd0, 39'h00_8000_0124, '0, 8'd0));
    end
    vectors++;
    if (idle !== 1'b0) begin
      miscompares++; $display("FAIL boot_idle: got %b want 0", idle);
    end
    step();
    vectors++;
    if ({cmd_v, idle} !== 2'b01) begin
      miscompares++; $display("FAIL boot_drained: got v/idle %b want 01", {cmd_v, idle});
    end
  endtask

  task automatic test_priority();
    redirect_v = 1'b1; redirect_pc = 39'h12_3456_789A;
    fill_v = 1'b1; fill_vaddr = 39'h00_ABCD_E000; fill_ptag = 28'hBEEF123;
    #1;
    vectors++;
    if ({redirect_ready, fill_ready} !== 2'b10) begin
      miscompares++; $display("FAIL prio_ready: got %b want 10", {redirect_ready, fill_ready});
    end
    step();
    redirect_v = 1'b0;
    #1;
    vectors++;
    if (fill_ready !== 1'b1) begin
      miscompares++; $display("FAIL prio_fill_ready: got %b want 1", fill_ready);
    end
    vectors++;
    if (head() !== exp_head(3'd1, 39'h12_3456_789A, '0, 8'd1)) begin
      miscompares++; $display("FAIL prio_redirect_head: got %h want %h", head(), exp_head(3'd1, 39'h12_3456_789A, '0, 8'd1));
    end
    step();
    fill_v = 1'b0;
    vectors++;
    if (head() !== exp_head(3'd2, 39'h00_ABCD_E000, 28'hBEEF123, 8'd2)) begin
      miscompares++; $display("FAIL prio_fill_head: got %h want %h", head(), exp_head(3'd2, 39'h00_ABCD_E000, 28'hBEEF123, 8'd2));
    end
    step();
    vectors++;
    if (cmd_v !== 1'b0) begin
      miscompares++; $display("FAIL prio_drained: got %b want 0", cmd_v);
    end
  endtask

  task automatic test_backpressure();
    cmd_ready = 1'b0;
    redirect_v = 1'b1; redirect_pc = 39'h100;
    #1;
    vectors++;
    if (redirect_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_first_ready: got %b want 1", redirect_ready);
    end
    step();
    redirect_pc = 39'h200;
    #1;
    vectors++;
    if (redirect_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_second_ready: got %b want 1", redirect_ready);
    end
    step();
    redirect_pc = 39'h300;
    #1;
    vectors++;
    if (redirect_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_full_ready: got %b want 0", redirect_ready);
    end
    step();
    vectors++;
    if ({redirect_ready, head()} !== {1'b0, exp_head(3'd1, 39'h100, '0, 8'd3)}) begin
      miscompares++; $display("FAIL bp_stalled: got %h want %h", {redirect_ready, head()}, {1'b0, exp_head(3'd1, 39'h100, '0, 8'd3)});
    end
    cmd_ready = 1'b1;
    #1;
    vectors++;
    if (redirect_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_no_passthrough: got %b want 0", redirect_ready);
    end
    step();
    cmd_ready = 1'b0;
    #1;
    vectors++;
    if (redirect_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_third_ready: got %b want 1", redirect_ready);
    end
    vectors++;
    if (head() !== exp_head(3'd1, 39'h200, '0, 8'd4)) begin
      miscompares++; $display("FAIL bp_second_head: got %h want %h", head(), exp_head(3'd1, 39'h200, '0, 8'd4));
    end
    step();
    redirect_v = 1'b0;
    cmd_ready = 1'b1;
    step();
    vectors++;
    if (head() !== exp_head(3'd1, 39'h300, '0, 8'd5)) begin
      miscompares++; $display("FAIL bp_third_head: got %h want %h", head(), exp_head(3'd1, 39'h300, '0, 8'd5));
    end
    step();
    vectors++;
    if ({cmd_v, idle} !== 2'b01) begin
      miscompares++; $display("FAIL bp_drained: got %b want 01", {cmd_v, idle});
    end
  endtask

  task automatic test_fence();
    cmd_ready = 1'b0;
    fence_v = 1'b1;
    #1;
    vectors++;
    if (fence_ready !== 1'b1) begin
      miscompares++; $display("FAIL fence_ready: got %b want 1", fence_ready);
    end
    step();
    fence_v = 1'b0;
    redirect_v = 1'b1; redirect_pc = 39'h7F_0000_0040;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({redirect_ready, idle, head()} !== {2'b00, exp_head(3'd3, '0, '0, 8'd6)}) begin
        miscompares++; $display("FAIL fence_wait_%0d: got %h want %h", i, {redirect_ready, idle, head()}, {2'b00, exp_head(3'd3, '0, '0, 8'd6)});
      end
      step();
    end
    cmd_ready = 1'b1;
    #1;
    vectors++;
    if (redirect_ready !== 1'b0) begin
      miscompares++; $display("FAIL fence_deq_cycle_ready: got %b want 0", redirect_ready);
    end
    step();
    vectors++;
    if ({redirect_ready, cmd_v} !== 2'b10) begin
      miscompares++; $display("FAIL fence_released: got %b want 10", {redirect_ready, cmd_v});
    end
    step();
    redirect_v = 1'b0;
    vectors++;
    if (head() !== exp_head(3'd1, 39'h7F_0000_0040, '0, 8'd7)) begin
      miscompares++; $display("FAIL fence_redirect_head: got %h want %h", head(), exp_head(3'd1, 39'h7F_0000_0040, '0, 8'd7));
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] tag;
    cmd_ready = 1'b1;
    redirect_v = 1'b1;
    for (int i = 0; i < 300; i++) begin
      redirect_pc = 39'h40_0000_0000 + 39'(i * 4);
      tag = 8'(8 + i);
      #1;
      vectors++;
      if (redirect_ready !== 1'b1) begin
        miscompares++; $display("FAIL b2b_ready_%0d: got %b want 1", i, redirect_ready);
      end
      step();
      vectors++;
      if (head() !== exp_head(3'd1, 39'h40_0000_0000 + 39'(i * 4), '0, tag)) begin
        miscompares++; $display("FAIL b2b_head_%0d: got %h want %h", i, head(), exp_head(3'd1, 39'h40_0000_0000 + 39'(i * 4), '0, tag));
      end
    end
    redirect_v = 1'b0;
    step();
    vectors++;
    if (cmd_v !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drained: got %b want 0", cmd_v);
    end
  endtask

  task automatic test_mid_reset();
    cmd_ready = 1'b0;
    redirect_v = 1'b1; redirect_pc = 39'h55;
    step();
    redirect_pc = 39'h66;
    step();
    redirect_v = 1'b0;
    vectors++;
    if (head() !== exp_head(3'd1, 39'h55, '0, 8'd52)) begin
      miscompares++; $display("FAIL mid_queued: got %h want %h", head(), exp_head(3'd1, 39'h55, '0, 8'd52));
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({head(), redirect_ready, idle} !== '0) begin
      miscompares++; $display("FAIL mid_async_clear: got %h want 0", {head(), redirect_ready, idle});
    end
    step();
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    step();
    vectors++;
    if (head() !== exp_head(3'd0, 39'h00_8000_0124, '0, 8'd0)) begin
      miscompares++; $display("FAIL mid_reboot: got %h want %h", head(), exp_head(3'd0, 39'h00_8000_0124, '0, 8'd0));
    end
    step();
    vectors++;
    if ({cmd_v, idle} !== 2'b01) begin
      miscompares++; $display("FAIL mid_only_boot: got %b want 01", {cmd_v, idle});
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_backpressure();
    test_fence();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
